mvu_job_scheduler: RTL and testbench
====================================

// Module: mvu_job_scheduler
// PURPOSE
//   Shares one MVU core among NREQ job requesters using round-robin arbitration.
//   For each granted job it drives the MVU config write and start pulse, waits for done,
//     and returns a completion response (with timeout detection) to the winning requester.
//   Sits between the host/command fabric and mvutop's configuration/control port.
// PARAMETERS
//   NREQ      4     number of requesters (>=2)
//   DESC_W    64    job descriptor width, forwarded opaque to the MVU config port
//   TIMEOUT   4096  max cycles in WAIT before abort; 0 disables the timeout
//   CNT_W     16    width of statistics counters
// PORTS
//   clk          in   1             system clock, all logic on posedge
//   rst          in   1             synchronous, active-high reset
//   req_valid    in   NREQ          per-requester job valid
//   req_ready    out  NREQ          per-requester accept (one-hot or zero)
//   req_desc     in   NREQ*DESC_W   packed descriptors; slice i belongs to requester i
//   cfg_we       out  1             MVU config write strobe
//   cfg_data     out  DESC_W        MVU config payload
//   mvu_start    out  1             one-cycle MVU start pulse
//   mvu_abort    out  1             one-cycle MVU abort pulse on timeout
//   mvu_done     in   1             MVU job-complete pulse
//   resp_valid   out  1             completion response valid
//   resp_ready   in   1             completion response accept
//   resp_id      out  $clog2(NREQ)  requester index of the completed job
//   resp_err     out  1             1 = job timed out and was aborted
//   busy         out  1             high in any state other than IDLE
//   jobs_done    out  CNT_W         successful completions, saturating
//   jobs_tmo     out  CNT_W         timed-out jobs, saturating
// BEHAVIOUR
//   Reset values: all outputs 0; FSM=IDLE; rr_ptr=NREQ-1, so requester 0 has top priority first.
//   FSM states: IDLE -> CFG -> START -> WAIT -> RESP -> IDLE.
//   IDLE
//     - Winner = first i with req_valid[i], searching from rr_ptr+1 upward modulo NREQ.
//     - req_ready[winner]=1 combinationally in the same cycle.
//     - Latch the winner's desc and id; next state CFG.
//     - No valid requests -> stay in IDLE.
//   CFG: cfg_we=1, cfg_data=latched desc for exactly 1 cycle; next state START.
//   START
//     - mvu_start=1 for exactly 1 cycle.
//     - Load tmo_cnt=TIMEOUT; next state WAIT.
//     - Handshake-to-start latency is fixed: mvu_start is asserted 2 cycles after the req_ready cycle.
//   WAIT
//     - mvu_done=1 -> RESP with err=0; jobs_done++.
//     - Otherwise, if TIMEOUT!=0, decrement tmo_cnt.
//     - When tmo_cnt reaches 1 with no done: mvu_abort=1 that cycle, go to RESP with err=1, jobs_tmo++.
//     - If done and timeout expiry coincide, done wins (err=0, no abort).
//   RESP
//     - resp_valid=1; resp_id and resp_err are stable while resp_valid is high.
//     - On resp_ready: rr_ptr<=resp_id, go to IDLE; the next grant is possible in the following cycle.
//   mvu_done outside WAIT is ignored: no state change and no counter update.
//   req_ready stays 0 in every state except IDLE; requests may stay asserted indefinitely.
//   Counters saturate at all-ones and do not wrap.
//   rst asserted mid-job: return to IDLE immediately, clear counters, and issue no abort pulse.
//     Driving any required MVU reset is the system's job.
//   A requester whose req_valid drops before it is granted is never served (no request memory).
// TESTING
//   1. Reset, then req_valid=4'b0001 with desc=64'hA5
//      -> req_ready[0] at cycle t; cfg_we with cfg_data=64'hA5 at t+1; mvu_start at t+2.
//   2. All 4 requesters held valid; mvu_done given 3 cycles after each start; resp_ready=1
//      -> grant order 0,1,2,3,0; jobs_done=5.
//   3. TIMEOUT=8 and mvu_done never asserted -> mvu_abort 8 cycles after mvu_start;
//      resp_err=1; jobs_tmo=1.
//   4. mvu_done in the same cycle as timeout expiry -> resp_err=0, mvu_abort stays 0, jobs_done++.
//   5. resp_ready held 0 for 10 cycles -> resp_valid, resp_id and resp_err stable;
//      req_ready stays 0; no new cfg_we.
//   6. rst pulsed during WAIT -> next cycle all outputs 0, busy=0; a pending req[2] is granted after reset.
//   7. Spurious mvu_done in IDLE or CFG -> counters unchanged; state sequence unaffected.

Source files
------------

// File: rtl/mvu_job_scheduler.sv
// mvu_job_scheduler
//   Shares one MVU core among NREQ job requesters. A round-robin arbiter picks
//   one pending job. The scheduler then writes that job's descriptor to the MVU
//   config port and pulses mvu_start. It waits for mvu_done, or aborts the job
//   when the timeout expires, and returns a completion response that names the
//   requester.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   req_valid     per-requester job valid
//   req_ready     per-requester accept, one-hot or zero, IDLE only
//   req_desc      packed descriptors, slice i belongs to requester i
//   cfg_we        MVU config write strobe (one cycle)
//   cfg_data      MVU config payload, driven while cfg_we is high
//   mvu_start     one-cycle MVU start pulse
//   mvu_abort     one-cycle MVU abort pulse on timeout
//   mvu_done      MVU job-complete pulse; honoured only in WAIT
//   resp_valid    completion response valid
//   resp_ready    completion response accept
//   resp_id       requester index of the completed job
//   resp_err      1 = job timed out and was aborted
//   busy          high in every state except IDLE
//   jobs_done     saturating count of successful completions
//   jobs_tmo      saturating count of timed-out jobs
//   state_dbg     current FSM state encoding (debug observation)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. The request side is combinational: req_ready depends
// on req_valid in the same cycle. Once resp_valid is raised it stays high,
// with resp_id and resp_err held, until the cycle in which resp_ready is seen.

module mvu_job_scheduler #(
    parameter int NREQ    = 4,
    parameter int DESC_W  = 64,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DESC_W-1:0]   req_desc,
    output logic                     cfg_we,
    output logic [DESC_W-1:0]        cfg_data,
    output logic                     mvu_start,
    output logic                     mvu_abort,
    input  logic                     mvu_done,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic                     resp_err,
    output logic                     busy,
    output logic [CNT_W-1:0]         jobs_done,
    output logic [CNT_W-1:0]         jobs_tmo,
    output logic [2:0]               state_dbg
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic [DESC_W-1:0]   desc_q;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                err_q;
    logic [CNT_W-1:0]    done_cnt;
    logic [CNT_W-1:0]    tmo_total;

    logic                found;
    logic [ID_W-1:0]     winner;
    logic [DESC_W-1:0]   desc_sel;
    logic                grant;
    logic                tmo_hit;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign desc_sel = req_desc[winner*DESC_W +: DESC_W];

    // No grant while reset is high, so a handshake cannot be lost to reset.
    assign grant = (state == S_IDLE) && found && !rst;

    // Expiry fires on the cycle the counter sits at 1. A coincident done wins.
    assign tmo_hit = (TIMEOUT != 0) && (state == S_WAIT) && !mvu_done &&
                     (tmo_cnt == TMO_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_CFG;
            S_CFG:   state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (mvu_done || tmo_hit) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: job latch, timeout counter, response, statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= ID_W'(NREQ - 1);
            id_q      <= '0;
            desc_q    <= '0;
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
            done_cnt  <= '0;
            tmo_total <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        id_q   <= winner;
                        desc_q <= desc_sel;
                    end
                end
                S_START: begin
                    tmo_cnt <= TMO_W'(TIMEOUT);
                end
                S_WAIT: begin
                    if (mvu_done) begin
                        err_q <= 1'b0;
                        if (done_cnt != '1) done_cnt <= done_cnt + CNT_W'(1);
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        if (tmo_total != '1) tmo_total <= tmo_total + CNT_W'(1);
                    end else if (TIMEOUT != 0) begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) rr_ptr <= id_q;
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        req_ready  = '0;
        cfg_we     = 1'b0;
        cfg_data   = '0;
        mvu_start  = 1'b0;
        mvu_abort  = 1'b0;
        resp_valid = 1'b0;
        resp_id    = '0;
        resp_err   = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:  if (grant) req_ready[winner] = 1'b1;
            S_CFG: begin
                cfg_we   = 1'b1;
                cfg_data = desc_q;
            end
            S_START: mvu_start = 1'b1;
            S_WAIT:  mvu_abort = tmo_hit && !rst;
            S_RESP: begin
                resp_valid = 1'b1;
                resp_id    = id_q;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

    assign jobs_done = done_cnt;
    assign jobs_tmo  = tmo_total;
    assign state_dbg = state;

endmodule

// File: tb/tb_mvu_job_scheduler.sv
module tb_mvu_job_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int TMO  = 8;
  localparam int CW   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_desc;
  logic                 cfg_we;
  logic [DW-1:0]        cfg_data;
  logic                 mvu_start;
  logic                 mvu_abort;
  logic                 mvu_done = 1'b0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b1;
  logic [1:0]           resp_id;
  logic                 resp_err;
  logic                 busy;
  logic [CW-1:0]        jobs_done;
  logic [CW-1:0]        jobs_tmo;
  logic [2:0]           state_dbg;

  logic [DW-1:0] desc [NREQ];
  assign req_desc = {desc[3], desc[2], desc[1], desc[0]};

  mvu_job_scheduler #(
    .NREQ(NREQ), .DESC_W(DW), .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_desc(req_desc),
    .cfg_we(cfg_we), .cfg_data(cfg_data),
    .mvu_start(mvu_start), .mvu_abort(mvu_abort), .mvu_done(mvu_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_err(resp_err),
    .busy(busy), .jobs_done(jobs_done), .jobs_tmo(jobs_tmo),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;
  int exp_tmo  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the rising edge; outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_jobs_done"}, jobs_done, exp_done);
    check({tag, "_jobs_tmo"}, jobs_tmo, exp_tmo);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    mvu_done = 1'b0;
    resp_ready = 1'b1;
    tick();
    tick();
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_cfg_we", cfg_we, 0);
    check("rst_start", mvu_start, 0);
    check("rst_abort", mvu_abort, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_jobs_tmo", jobs_tmo, 0);
    rst = 1'b0;
    exp_done = 0;
    exp_tmo = 0;
  endtask

  // One full job: grant, cfg, start, wait (done after dly cycles or timeout when dly==0),
  // response (held for hold cycles), return to IDLE.
  task automatic run_job(input logic [3:0] v, input int dly, input logic err_e,
                         input int hold, input bit spur);
    int n;
    logic [1:0] id_e;
    logic [1:0] id_h;
    logic       err_h;
    req_valid = v;
    mvu_done = spur;
    resp_ready = (hold == 0);
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      tick();
      #1;
      n++;
    end
    id_e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
    check("grant_onehot", req_ready, 4'b0001 << id_e);
    check("busy_at_grant", busy, 0);
    tick();
    #1;
    check("cfg_we", cfg_we, 1);
    check("cfg_data", cfg_data, desc[id_e]);
    check("ready_in_cfg", req_ready, 0);
    check("start_in_cfg", mvu_start, 0);
    tick();
    mvu_done = 1'b0;
    #1;
    check("mvu_start", mvu_start, 1);
    check("cfg_we_after", cfg_we, 0);
    check("busy_start", busy, 1);
    if (dly == 0) begin
      n = 0;
      do begin
        tick();
        #1;
        n++;
      end while (!mvu_abort && n < 40);
      check("abort_latency", n, TMO);
      exp_tmo = sat_inc(exp_tmo);
    end else begin
      for (int d = 1; d <= dly; d++) begin
        tick();
        if (d == dly) mvu_done = 1'b1;
        #1;
        check("no_abort", mvu_abort, 0);
        check("wait_no_resp", resp_valid, 0);
      end
      exp_done = sat_inc(exp_done);
    end
    tick();
    mvu_done = 1'b0;
    #1;
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, id_e);
    check("resp_err", resp_err, err_e);
    check("abort_one_cycle", mvu_abort, 0);
    check("ready_in_resp", req_ready, 0);
    id_h = resp_id;
    err_h = resp_err;
    for (int h = 0; h < hold; h++) begin
      tick();
      #1;
      check("hold_valid", resp_valid, 1);
      check("hold_id", resp_id, id_h);
      check("hold_err", resp_err, err_h);
      check("hold_ready", req_ready, 0);
      check("hold_cfg_we", cfg_we, 0);
    end
    resp_ready = 1'b1;
    tick();
    #1;
    check("back_idle", busy, 0);
    check_counters("post_job");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst_first;
    logic [3:0] valid;
    int         dly;
    logic [1:0] id;
    logic       err;
    int         hold;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    desc[0] = 64'h0000_0000_0000_00A5;
    desc[1] = 64'h1111_2222_3333_4444;
    desc[2] = 64'hDEAD_BEEF_0000_0002;
    desc[3] = 64'hF0F0_0F0F_CAFE_0003;

    //            rst   valid    dly id    err  hold
    vecs[0] = '{1'b1, 4'b0001, 3, 2'd0, 1'b0, 0};  // single requester latency
    vecs[1] = '{1'b1, 4'b1111, 3, 2'd0, 1'b0, 0};  // fresh reset: 0,1,2,3,0
    vecs[2] = '{1'b0, 4'b1111, 3, 2'd1, 1'b0, 0};
    vecs[3] = '{1'b0, 4'b1111, 3, 2'd2, 1'b0, 0};
    vecs[4] = '{1'b0, 4'b1111, 3, 2'd3, 1'b0, 0};
    vecs[5] = '{1'b0, 4'b1111, 3, 2'd0, 1'b0, 0};
    vecs[6] = '{1'b0, 4'b0100, 0, 2'd2, 1'b1, 0};  // timeout, abort after 8
    vecs[7] = '{1'b0, 4'b1010, 8, 2'd3, 1'b0, 0};  // done coincides with expiry
    vecs[8] = '{1'b0, 4'b1010, 1, 2'd1, 1'b0, 0};  // jobs_done saturates at 7
    vecs[9] = '{1'b0, 4'b0110, 2, 2'd2, 1'b0, 10}; // response back-pressure

    do_reset();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst_first) do_reset();
      exp_q.push_back(vecs[i].id);
      run_job(vecs[i].valid, vecs[i].dly, vecs[i].err, vecs[i].hold, 1'b0);
      if (i == 5) begin
        check("rr_five_jobs_done", jobs_done, 5);
        check("rr_five_jobs_tmo", jobs_tmo, 0);
      end
    end

    // Reset during WAIT: no abort, everything cleared, pending req[2] served next.
    req_valid = 4'b0101;   // rr_ptr=2 -> requester 0 wins
    #1;
    check("pre_rst_grant", req_ready, 4'b0001);
    tick();
    tick();
    tick();
    #1;
    check("pre_rst_in_wait", state_dbg, 3);
    req_valid = 4'b0100;
    rst = 1'b1;
    #1;
    check("rst_no_abort", mvu_abort, 0);
    tick();
    rst = 1'b0;
    #1;
    exp_done = 0;
    exp_tmo = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cfg_we", cfg_we, 0);
    check("mid_rst_start", mvu_start, 0);
    check("mid_rst_abort", mvu_abort, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_resp_id", resp_id, 0);
    check("mid_rst_resp_err", resp_err, 0);
    check_counters("mid_rst");
    exp_q.push_back(2'd2);
    run_job(4'b0100, 3, 1'b0, 0, 1'b0);

    // Spurious mvu_done in IDLE is ignored.
    req_valid = '0;
    mvu_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      check("spur_idle_busy", busy, 0);
      check_counters("spur_idle");
    end
    mvu_done = 1'b0;

    // Spurious mvu_done during the grant and CFG cycles: sequence unchanged.
    exp_q.push_back(2'd1);
    run_job(4'b0010, 3, 1'b0, 0, 1'b1);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
